// File: rtl/cnc_pkg.sv
// Shared definitions for the CNC result collector: default word width,
// capture-state enumeration and the complex result pair record.
package cnc_pkg;

    localparam int unsigned CNC_WIDTH = 17;

    typedef enum logic {
        S_RE = 1'b0,
        S_IM = 1'b1
    } cnc_state_t;

    typedef struct packed {
        logic [CNC_WIDTH-1:0] re;
        logic [CNC_WIDTH-1:0] im;
    } cnc_pair_t;

endpackage

// File: rtl/cnc_pair_fifo.sv
// First-word-fall-through FIFO of {re, im} pairs held in a register array.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module cnc_pair_fifo
    import cnc_pkg::*;
#(
    parameter int unsigned WIDTH = CNC_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [2*WIDTH-1:0]         push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [2*WIDTH-1:0]         head_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign rd_en     = pop && !empty;
    assign wr_en     = push && (!full || rd_en);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cnc_result_collector.sv
// Collects real/imaginary result words from the calculator into pairs and
// buffers them in a FWFT FIFO, with sticky overflow and framing-error flags.
module cnc_result_collector
    import cnc_pkg::*;
#(
    parameter int unsigned WIDTH = CNC_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   IN_VALID,
    input  logic [WIDTH-1:0]       IN,
    input  logic                   OUT_READY,
    output logic                   OUT_VALID,
    output logic [WIDTH-1:0]       OUT_RE,
    output logic [WIDTH-1:0]       OUT_IM,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   OVERFLOW,
    output logic                   FRAME_ERR
);

    cnc_state_t         state;
    logic [WIDTH-1:0]   held_re;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [2*WIDTH-1:0] head_data;

    // The imaginary word goes straight into the FIFO on the edge it is
    // sampled, so the pair is visible right after that edge.
    assign push      = (state == S_IM) && IN_VALID;
    assign pop       = OUT_VALID && OUT_READY;
    assign OUT_VALID = !empty;
    assign OUT_RE    = head_data[2*WIDTH-1:WIDTH];
    assign OUT_IM    = head_data[WIDTH-1:0];

    cnc_pair_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({held_re, IN}),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .level    (LEVEL),
        .head_data(head_data)
    );

    // Capture FSM: real word then imaginary word; a gap after the real word is a framing error
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RE;
            held_re   <= '0;
            FRAME_ERR <= 1'b0;
        end else begin
            case (state)
                S_RE: begin
                    if (IN_VALID) begin
                        held_re <= IN;
                        state   <= S_IM;
                    end
                end
                S_IM: begin
                    if (!IN_VALID) begin
                        FRAME_ERR <= 1'b1;
                    end
                    state <= S_RE;
                end
                default: state <= S_RE;
            endcase
        end
    end

    // Sticky overflow: a completed pair found the FIFO full with no pop to make room
    always_ff @(posedge clk) begin
        if (rst) begin
            OVERFLOW <= 1'b0;
        end else if (push && full && !pop) begin
            OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cnc_result_collector.sv
// Self-checking bench for cnc_result_collector: directed scenarios plus
// randomized traffic compared against a queue-based frame model.
module tb_cnc_result_collector;
    import cnc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_VALID;
    logic [16:0] IN;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [16:0] OUT_RE;
    logic [16:0] OUT_IM;
    logic [2:0]  LEVEL;
    logic        OVERFLOW;
    logic        FRAME_ERR;

    int checks = 0;
    int errors = 0;

    // Reference model state
    cnc_pair_t   q[$];
    bit          have_re;
    logic [16:0] held;
    bit          m_ovf;
    bit          m_ferr;

    always #5 clk = ~clk;

    cnc_result_collector #(.WIDTH(17), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .IN_VALID (IN_VALID),
        .IN       (IN),
        .OUT_READY(OUT_READY),
        .OUT_VALID(OUT_VALID),
        .OUT_RE   (OUT_RE),
        .OUT_IM   (OUT_IM),
        .LEVEL    (LEVEL),
        .OVERFLOW (OVERFLOW),
        .FRAME_ERR(FRAME_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        cnc_pair_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
        chk("out_re",    32'(OUT_RE),    32'(h.re));
        chk("out_im",    32'(OUT_IM),    32'(h.im));
        chk("level",     32'(LEVEL),     32'(q.size()));
        chk("overflow",  32'(OVERFLOW),  32'(m_ovf));
        chk("frame_err", 32'(FRAME_ERR), 32'(m_ferr));
    endtask

    // One clock: apply inputs, advance model at the edge, check 1 time unit later
    task automatic step(input logic r, input logic iv, input logic [16:0] d, input logic rdy);
        bit        pop_now;
        bit        was_full;
        bit        push_now;
        cnc_pair_t pr;
        rst = r; IN_VALID = iv; IN = d; OUT_READY = rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            have_re = 0; m_ovf = 0; m_ferr = 0;
        end else begin
            pop_now  = (q.size() != 0) && rdy;
            was_full = (q.size() == DEPTH);
            push_now = 0;
            pr       = '0;
            if (have_re) begin
                if (iv) begin
                    push_now = 1;
                    pr.re = held;
                    pr.im = d;
                end else begin
                    m_ferr = 1;
                end
                have_re = 0;
            end else if (iv) begin
                have_re = 1;
                held = d;
            end
            if (pop_now) void'(q.pop_front());
            if (push_now) begin
                if (!was_full || pop_now) q.push_back(pr);
                else m_ovf = 1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && q.size() != 0; i++) step(0, 0, '0, 1);
        chk("drain_empty", 32'(OUT_VALID), 32'(0));
    endtask

    initial begin
        rst = 1'b1; IN_VALID = 1'b0; IN = '0; OUT_READY = 1'b0;
        have_re = 0; m_ovf = 0; m_ferr = 0; held = '0;

        // Reset state
        step(1, 0, '0, 0);
        step(1, 1, 17'h1ABCD, 1);
        chk("reset_level", 32'(LEVEL), 32'(0));
        chk("reset_valid", 32'(OUT_VALID), 32'(0));

        // Single frame with consumer ready
        step(0, 1, 17'h00012, 1);
        step(0, 1, 17'h1FFF3, 1);
        chk("single_re", 32'(OUT_RE), 32'h00012);
        chk("single_im", 32'(OUT_IM), 32'h1FFF3);
        step(0, 0, '0, 1);
        chk("single_level", 32'(LEVEL), 32'(0));

        // Fill and overflow: five frames, values 1..10, no consumer
        step(1, 0, '0, 0);
        for (int v = 1; v <= 10; v++) step(0, 1, 17'(v), 0);
        chk("fill_level", 32'(LEVEL), 32'(4));
        chk("fill_ovf", 32'(OVERFLOW), 32'(1));
        for (int i = 0; i < 4; i++) begin
            chk("fill_re", 32'(OUT_RE), 32'(2 * i + 1));
            chk("fill_im", 32'(OUT_IM), 32'(2 * i + 2));
            step(0, 0, '0, 1);
        end
        chk("fill_empty", 32'(OUT_VALID), 32'(0));

        // Full with simultaneous pop on the fifth pair's imaginary edge
        step(1, 0, '0, 0);
        for (int v = 1; v <= 9; v++) step(0, 1, 17'(v), 0);
        step(0, 1, 17'd10, 1);
        chk("simul_level", 32'(LEVEL), 32'(4));
        chk("simul_ovf", 32'(OVERFLOW), 32'(0));
        drain();

        // Broken frame followed by a good one
        step(1, 0, '0, 0);
        step(0, 1, 17'd7, 0);
        step(0, 0, '0, 0);
        step(0, 1, 17'd8, 0);
        step(0, 1, 17'd9, 0);
        chk("broken_ferr", 32'(FRAME_ERR), 32'(1));
        chk("broken_pair", {OUT_RE[15:0], OUT_IM[15:0]}, {16'd8, 16'd9});
        chk("broken_level", 32'(LEVEL), 32'(1));
        drain();

        // Reset mid-frame with two pairs stored
        step(1, 0, '0, 0);
        for (int v = 1; v <= 5; v++) step(0, 1, 17'(v * 3), 0);
        chk("midrst_pre", 32'(LEVEL), 32'(2));
        step(1, 0, '0, 0);
        chk("midrst_level", 32'(LEVEL), 32'(0));
        step(0, 1, 17'd5, 0);
        step(0, 1, 17'd6, 0);
        chk("midrst_pair", {OUT_RE[15:0], OUT_IM[15:0]}, {16'd5, 16'd6});
        drain();

        // Pointer wrap: 12 frames with ready toggling every cycle
        step(1, 0, '0, 0);
        for (int i = 0; i < 24; i++) step(0, 1, 17'(100 + i), 1'(i % 2));
        drain();
        chk("wrap_ovf", 32'(OVERFLOW), 32'(0));

        // Randomized traffic
        step(1, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 7) != 0),
                 17'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
